// File: rtl/async_frame_receiver_if.sv
// rtl/async_frame_receiver_if.sv - serial line and frame handshake bundle for async_frame_receiver
interface async_frame_receiver_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  RXD;
  logic                  DATA_ACK;
  logic [DATA_WIDTH-1:0] Frame;
  logic                  RX_BUSY;
  logic                  RX_READY;
  logic                  RX_ERROR;

  modport master (output RXD, output DATA_ACK,
                  input Frame, input RX_BUSY, input RX_READY, input RX_ERROR);
  modport slave  (input RXD, input DATA_ACK,
                  output Frame, output RX_BUSY, output RX_READY, output RX_ERROR);
endinterface

// File: rtl/async_frame_receiver.sv
// rtl/async_frame_receiver.sv - oversampling async frame receiver with ready/ack handshake
// Optional even-parity bit enabled by defining RX_PARITY_EN.
module async_frame_receiver #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 10
) (
  input logic                   CLK,
  input logic                   nRST,
  async_frame_receiver_if.slave rx
);
  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  sync1_q, sync1_d;
  logic                  rxs_q, rxs_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
`ifdef RX_PARITY_EN
  logic                  par_acc_q, par_acc_d;
  logic                  par_err_q, par_err_d;
`endif
  logic                  maj;
  logic                  done_ok;
  logic                  set_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    frame_d = frame_q;
    sync1_d = rx.RXD;
    rxs_d   = sync1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    ready_d = ready_q;
    error_d = error_q;
`ifdef RX_PARITY_EN
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
`endif
    done_ok = 1'b0;
    set_err = 1'b0;
    // The third sample is the live rxs at the decision cycle.
    maj = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

    if (state_q != S_IDLE) cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_S0) s0_d = rxs_q;
    if (cnt_q == CNT_S1) s1_d = rxs_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CW'(1);
`ifdef RX_PARITY_EN
          par_acc_d = 1'b0;
          par_err_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt_q == CNT_DEC && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_DEC) begin
          shift_d[idx_q] = maj;
`ifdef RX_PARITY_EN
          par_acc_d = par_acc_q ^ maj;
`endif
        end
        if (cnt_q == CNT_LAST) begin
          if (idx_q == IDX_LAST) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_DEC) par_err_d = par_acc_q ^ maj;
        if (cnt_q == CNT_LAST) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Good stop returns to IDLE mid-bit so the next start edge is not missed.
        if (cnt_q == CNT_DEC) begin
          cnt_d = '0;
          if (maj) begin
            state_d = S_IDLE;
`ifdef RX_PARITY_EN
            if (par_err_q) set_err = 1'b1;
            else           done_ok = 1'b1;
`else
            done_ok = 1'b1;
`endif
          end else begin
            state_d = S_WAIT_IDLE;
            set_err = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (rx.DATA_ACK) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end
    if (done_ok) begin
      if (!ready_q || rx.DATA_ACK) begin
        frame_d = shift_q;
        ready_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
    if (set_err) error_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      frame_q <= '0;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      error_q <= error_d;
`ifdef RX_PARITY_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign rx.Frame    = frame_q;
  assign rx.RX_BUSY  = busy_q;
  assign rx.RX_READY = ready_q;
  assign rx.RX_ERROR = error_q;
endmodule

// File: tb/tb_async_frame_receiver.sv
// tb/tb_async_frame_receiver.sv - directed self-checking bench for async_frame_receiver
module tb_async_frame_receiver;
  localparam int OS = 8;
  localparam int DW = 10;
`ifdef RX_PARITY_EN
  localparam int LAT = (DW + 1) * OS + OS / 2 + 1 + OS;
`else
  localparam int LAT = (DW + 1) * OS + OS / 2 + 1;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  async_frame_receiver_if #(.DATA_WIDTH(DW)) bus ();

  async_frame_receiver #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .rx   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.RXD = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop, input int stop_len);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) bus.RXD = 1'b0;
`endif
    bus.RXD = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic wait_high(input int sel, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((sel == 0) ? bus.RX_BUSY : bus.RX_READY) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check(sel == 0 ? "busy_timeout" : "ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_pulse();
    bus.DATA_ACK = 1'b1;
    @(negedge clk);
    bus.DATA_ACK = 1'b0;
  endtask

  int t_busy, t_rdy;

  initial begin
    bus.RXD = 1'b1;
    bus.DATA_ACK = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.RX_BUSY, 0);
    check("rst_ready", bus.RX_READY, 0);
    check("rst_error", bus.RX_ERROR, 0);
    check("rst_frame", bus.Frame, 0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // basic frame with latency from RX_BUSY rise to RX_READY rise
    fork
      send_frame(10'h2A5, ^10'h2A5, 1'b1, OS);
      begin
        wait_high(0, t_busy);
        wait_high(1, t_rdy);
        check("latency", t_rdy - t_busy, LAT);
      end
    join
    check("f1_frame", bus.Frame, 10'h2A5);
    check("f1_error", bus.RX_ERROR, 0);
    check("f1_ready", bus.RX_READY, 1);
    ack_pulse();
    check("f1_ack_ready", bus.RX_READY, 0);

    // 3-cycle glitch: false start
    bus.RXD = 1'b0;
    repeat (3) @(negedge clk);
    bus.RXD = 1'b1;
    check("gl_busy_hi", bus.RX_BUSY, 1);
    repeat (10) @(negedge clk);
    check("gl_busy_lo", bus.RX_BUSY, 0);
    check("gl_ready", bus.RX_READY, 0);
    check("gl_error", bus.RX_ERROR, 0);

    // framing error, line held low after the bad stop
    send_frame(10'h155, ^10'h155, 1'b0, 20);
    check("fe_error", bus.RX_ERROR, 1);
    check("fe_ready", bus.RX_READY, 0);
    check("fe_frame", bus.Frame, 10'h2A5);
    check("fe_busy", bus.RX_BUSY, 1);
    bus.RXD = 1'b1;
    repeat (2) @(negedge clk);
    check("fe_busy_hold", bus.RX_BUSY, 1);
    @(negedge clk);
    check("fe_busy_lo", bus.RX_BUSY, 0);
    ack_pulse();
    check("fe_ack_error", bus.RX_ERROR, 0);

    // overrun: back-to-back frames, no acknowledge
    send_frame(10'h001, ^10'h001, 1'b1, OS);
    send_frame(10'h3FF, ^10'h3FF, 1'b1, OS);
    repeat (10) @(negedge clk);
    check("ov_frame", bus.Frame, 10'h001);
    check("ov_ready", bus.RX_READY, 1);
    check("ov_error", bus.RX_ERROR, 1);
    ack_pulse();
    check("ov_ack_ready", bus.RX_READY, 0);
    check("ov_ack_error", bus.RX_ERROR, 0);

`ifdef RX_PARITY_EN
    send_frame(10'h003, 1'b1, 1'b1, OS);
    repeat (4) @(negedge clk);
    check("pe_error", bus.RX_ERROR, 1);
    check("pe_ready", bus.RX_READY, 0);
    check("pe_frame", bus.Frame, 10'h001);
    ack_pulse();
    fork
      send_frame(10'h003, 1'b0, 1'b1, OS);
      begin
        wait_high(0, t_busy);
        wait_high(1, t_rdy);
        check("p_latency", t_rdy - t_busy, LAT);
      end
    join
    check("p_frame", bus.Frame, 10'h003);
    check("p_error", bus.RX_ERROR, 0);
    ack_pulse();
`endif

    // acknowledge in the same cycle as the second completion
    fork
      begin
        send_frame(10'h001, ^10'h001, 1'b1, OS);
        send_frame(10'h3FF, ^10'h3FF, 1'b1, OS);
      end
      begin
        wait_high(0, t_busy);
        wait_high(1, t_rdy);
        check("sa_first_frame", bus.Frame, 10'h001);
        wait_high(0, t_busy);
        while (cyc < t_busy + LAT - 1) @(negedge clk);
        check("sa_pre_ready", bus.RX_READY, 1);
        ack_pulse();
        check("sa_frame", bus.Frame, 10'h3FF);
        check("sa_ready", bus.RX_READY, 1);
        check("sa_error", bus.RX_ERROR, 0);
      end
    join
    repeat (4) @(negedge clk);

    // reset mid-DATA, leftover bits may form a junk frame that is acknowledged away
    fork
      send_frame(10'h0F0, ^10'h0F0, 1'b1, OS);
      begin
        repeat (OS * 6 + 3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("mr_busy", bus.RX_BUSY, 0);
        check("mr_ready", bus.RX_READY, 0);
        check("mr_error", bus.RX_ERROR, 0);
        check("mr_frame", bus.Frame, 0);
      end
    join
    repeat (120) @(negedge clk);
    ack_pulse();
    check("mr_idle_busy", bus.RX_BUSY, 0);
    check("mr_idle_ready", bus.RX_READY, 0);
    send_frame(10'h30C, ^10'h30C, 1'b1, OS);
    repeat (4) @(negedge clk);
    check("mr_next_frame", bus.Frame, 10'h30C);
    check("mr_next_ready", bus.RX_READY, 1);
    check("mr_next_error", bus.RX_ERROR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
